// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: mul/div sequencer states and the default widths/latency
// used by the hazard controller and its interface.
package pipeline_pkg;

  localparam int REG_BITS_DEFAULT   = 5;
  localparam int MD_LATENCY_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard controller bus: ID/EX hazard sources from the pipeline and the stall/flush
// enables plus mul/div handshake returned to it.
interface hazard_controller_if #(
  parameter int REG_BITS = pipeline_pkg::REG_BITS_DEFAULT
);

  logic [REG_BITS-1:0] rsD;
  logic [REG_BITS-1:0] rtD;
  logic [REG_BITS-1:0] writeRegisterE;
  logic                regWriteE;
  logic                memToRegE;
  logic                branchTakenE;
  logic                mdReqE;

  logic                stallF;
  logic                stallD;
  logic                stallE;
  logic                flushD;
  logic                flushE;
  logic                flushM;
  logic                mdStart;
  logic                mdBusy;
  logic                mdResultValid;

  modport master (
    output rsD, rtD, writeRegisterE, regWriteE, memToRegE, branchTakenE, mdReqE,
    input  stallF, stallD, stallE, flushD, flushE, flushM, mdStart, mdBusy, mdResultValid
  );

  modport slave (
    input  rsD, rtD, writeRegisterE, regWriteE, memToRegE, branchTakenE, mdReqE,
    output stallF, stallD, stallE, flushD, flushE, flushM, mdStart, mdBusy, mdResultValid
  );

endinterface

// File: rtl/hazard_controller_md_sequencer.sv
// Mul/div sequencer: freezes the front of the pipeline for MD_LATENCY cycles per op,
// then flags one cycle in which the result may be captured into EX/MEM.
module md_sequencer
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      mdReqE,
  output logic      mdStart,
  output logic      mdBusy,
  output logic      mdResultValid,
  output logic      mdStall,
  output md_state_t state
);

  localparam int                  CNT_BITS = $clog2(MD_LATENCY + 1);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MD_LATENCY - 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(1);

  logic [CNT_BITS-1:0] cnt;

  // The request cycle itself is the first stall cycle, so BUSY only covers the
  // remaining MD_LATENCY-1 cycles; a latency of 1 skips BUSY entirely.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mdBusy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mdReqE) begin
            cnt <= CNT_LOAD;
            if (MD_LATENCY == 1) begin
              state  <= DONE;
              mdBusy <= 1'b0;
            end else begin
              state  <= BUSY;
              mdBusy <= 1'b1;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            state  <= DONE;
            mdBusy <= 1'b0;
          end
        end
        DONE: begin
          state  <= IDLE;
          mdBusy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          mdBusy <= 1'b0;
        end
      endcase
    end
  end

  assign mdStart       = !reset && (state == IDLE) && mdReqE;
  assign mdResultValid = !reset && (state == DONE);
  assign mdStall       = mdStart || (!reset && (state == BUSY));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: merges mul/div freezes with load-use stalls and
// taken-branch flushes into the pipeline register stall/flush enables.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int REG_BITS   = REG_BITS_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  hazard_controller_if.slave bus
);

  localparam logic [REG_BITS-1:0] ZERO_REG = '0;

  md_state_t mdState;
  logic      mdStall;
  logic      hazardWindow;
  logic      loadUse;
  logic      branchFlush;
  logic      loadStall;

  md_sequencer #(
    .MD_LATENCY(MD_LATENCY)
  ) sequencer (
    .clk          (clk),
    .reset        (reset),
    .mdReqE       (bus.mdReqE),
    .mdStart      (bus.mdStart),
    .mdBusy       (bus.mdBusy),
    .mdResultValid(bus.mdResultValid),
    .mdStall      (mdStall),
    .state        (mdState)
  );

  // Load-use and branch handling only apply in IDLE, and a mul/div request wins over both.
  assign hazardWindow = !reset && (mdState == IDLE) && !bus.mdReqE;

  assign loadUse = bus.memToRegE && bus.regWriteE && (bus.writeRegisterE != ZERO_REG) &&
                   ((bus.writeRegisterE == bus.rsD) || (bus.writeRegisterE == bus.rtD));

  // A taken branch squashes the ID instruction, so its load-use stall is pointless.
  assign branchFlush = hazardWindow && bus.branchTakenE;
  assign loadStall   = hazardWindow && !bus.branchTakenE && loadUse;

  assign bus.stallF = mdStall || loadStall;
  assign bus.stallD = mdStall || loadStall;
  assign bus.stallE = mdStall;
  assign bus.flushD = branchFlush;
  assign bus.flushE = branchFlush || loadStall;
  assign bus.flushM = mdStall;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: an MD_LATENCY=8 instance for hazards and
// mul/div sequencing, plus an MD_LATENCY=1 instance for the short-latency case.
module tb_hazard_controller;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  hazard_controller_if #(.REG_BITS(5)) busA ();
  hazard_controller_if #(.REG_BITS(5)) busB ();

  hazard_controller #(.MD_LATENCY(8), .REG_BITS(5)) dutA (
    .clk  (clk),
    .reset(reset),
    .bus  (busA)
  );

  hazard_controller #(.MD_LATENCY(1), .REG_BITS(5)) dutB (
    .clk  (clk),
    .reset(reset),
    .bus  (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: stallF stallD stallE flushD flushE flushM mdStart mdBusy mdResultValid
  localparam logic [8:0] NONE   = 9'b000_000_000;
  localparam logic [8:0] LDUSE  = 9'b110_010_000;
  localparam logic [8:0] BRANCH = 9'b000_110_000;
  localparam logic [8:0] START  = 9'b111_001_100;
  localparam logic [8:0] BUSYV  = 9'b111_001_010;
  localparam logic [8:0] VALID  = 9'b000_000_001;

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                               input logic regW, input logic memR, input logic br,
                               input logic md);
    @(posedge clk);
    #2;
    busA.rsD            = rs;
    busA.rtD            = rt;
    busA.writeRegisterE = wr;
    busA.regWriteE      = regW;
    busA.memToRegE      = memR;
    busA.branchTakenE   = br;
    busA.mdReqE         = md;
    #1;
  endtask

  task automatic checkOutput(input string tag, input bit useB, input logic [8:0] expected);
    logic [8:0] observed;
    if (useB)
      observed = {busB.stallF, busB.stallD, busB.stallE, busB.flushD, busB.flushE,
                  busB.flushM, busB.mdStart, busB.mdBusy, busB.mdResultValid};
    else
      observed = {busA.stallF, busA.stallD, busA.stallE, busA.flushD, busA.flushE,
                  busA.flushM, busA.mdStart, busA.mdBusy, busA.mdResultValid};
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    busB.rsD            = '0;
    busB.rtD            = '0;
    busB.writeRegisterE = '0;
    busB.regWriteE      = 1'b0;
    busB.memToRegE      = 1'b0;
    busB.branchTakenE   = 1'b0;
    busB.mdReqE         = 1'b0;

    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_with_req", 1'b0, NONE);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_a", 1'b0, NONE);
    checkOutput("reset_b", 1'b1, NONE);

    reset = 1'b0;
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_quiet", 1'b0, NONE);

    applyStimulus(5'd5, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("loaduse_rs", 1'b0, LDUSE);
    applyStimulus(5'd3, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("loaduse_rt", 1'b0, LDUSE);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("loaduse_r0", 1'b0, NONE);
    applyStimulus(5'd5, 5'd3, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("loaduse_noregwrite", 1'b0, NONE);
    applyStimulus(5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("alu_not_load", 1'b0, NONE);
    applyStimulus(5'd6, 5'd7, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("loaduse_nomatch", 1'b0, NONE);
    applyStimulus(5'd5, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("branch_over_loaduse", 1'b0, BRANCH);
    applyStimulus(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("branch_only", 1'b0, BRANCH);

    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("md_start_beats_branch", 1'b0, START);
    for (int k = 1; k <= 7; k++) begin
      if (k == 3)
        applyStimulus(5'd5, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
      else if (k == 5)
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      else
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("md_busy_%0d", k), 1'b0, BUSYV);
    end
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("md_done_ignores_req", 1'b0, VALID);

    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("md2_start", 1'b0, START);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("md2_busy_%0d", k), 1'b0, BUSYV);
    end
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("md2_done", 1'b0, VALID);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("md2_idle", 1'b0, NONE);

    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("md3_start", 1'b0, START);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("md3_busy_1", 1'b0, BUSYV);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("md3_busy_2", 1'b0, BUSYV);
    reset = 1'b1;
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("md3_after_reset", 1'b0, NONE);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("md3_no_result_%0d", k), 1'b0, NONE);
    end

    @(posedge clk);
    #2;
    busB.mdReqE = 1'b1;
    #1;
    checkOutput("lat1_start", 1'b1, START);
    @(posedge clk);
    #2;
    busB.mdReqE = 1'b0;
    #1;
    checkOutput("lat1_done", 1'b1, VALID);
    @(posedge clk);
    #3;
    checkOutput("lat1_idle", 1'b1, NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
